// File: rtl/min_max_accel_pkg.sv
// Shared definitions for the packed-int8 min/max accelerator and its command sequencer.
// Function ids, lane geometry and the sequencer state encoding live here.
package min_max_accel_pkg;

   localparam int LANE_W = 8;
   localparam int LANES  = 4;

   localparam logic [9:0] FN_SET_TYPE = 10'd0;
   localparam logic [9:0] FN_MAX      = 10'd1;
   localparam logic [9:0] FN_MIN      = 10'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_CFG_RSP,
      ST_FIRST,
      ST_OP,
      ST_OP_RSP,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/user_def_min_max_reduce_seq.sv
// Folds a stream of packed 4x8-bit words through the min/max accelerator, one pair per command,
// leaving the lane-wise max or min of the whole vector in result.
module user_def_min_max_reduce_seq
   import min_max_accel_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    op_min,
   input  logic                    is_signed,
   input  logic [LEN_W-1:0]        len,
   output logic                    busy,
   output logic                    done,
   output logic [LANE_W*LANES-1:0] result,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANE_W*LANES-1:0] in_data,
   output logic                    m_cmd_valid,
   input  logic                    m_cmd_ready,
   output logic [9:0]              m_cmd_function_id,
   output logic [LANE_W*LANES-1:0] m_cmd_inputs_0,
   output logic [LANE_W*LANES-1:0] m_cmd_inputs_1,
   input  logic                    m_rsp_valid,
   output logic                    m_rsp_ready,
   input  logic [LANE_W*LANES-1:0] m_rsp_outputs_0
);

   localparam int DATA_W = LANE_W * LANES;
   localparam logic [LEN_W-1:0] LEN_ZERO = '0;
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   seq_state_t        state;
   logic              op_min_q;
   logic              signed_q;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] acc;

   // result is written on the transition into DONE so it is already valid while done pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         op_min_q  <= 1'b0;
         signed_q  <= 1'b0;
         remaining <= '0;
         acc       <= '0;
         result    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len == LEN_ZERO) begin
                     result <= '0;
                     state  <= ST_DONE;
                  end else begin
                     op_min_q  <= op_min;
                     signed_q  <= is_signed;
                     remaining <= len - LEN_ONE;
                     state     <= ST_CFG;
                  end
               end
            end
            ST_CFG: begin
               if (m_cmd_ready) state <= ST_CFG_RSP;
            end
            ST_CFG_RSP: begin
               if (m_rsp_valid) state <= ST_FIRST;
            end
            ST_FIRST: begin
               if (in_valid) begin
                  acc <= in_data;
                  if (remaining == LEN_ZERO) begin
                     result <= in_data;
                     state  <= ST_DONE;
                  end else begin
                     state <= ST_OP;
                  end
               end
            end
            ST_OP: begin
               if (in_valid && m_cmd_ready) state <= ST_OP_RSP;
            end
            ST_OP_RSP: begin
               // remaining is at least 1 here, so the decrement cannot wrap
               if (m_rsp_valid) begin
                  acc       <= m_rsp_outputs_0;
                  remaining <= remaining - LEN_ONE;
                  if (remaining == LEN_ONE) begin
                     result <= m_rsp_outputs_0;
                     state  <= ST_DONE;
                  end else begin
                     state <= ST_OP;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // in_ready follows m_cmd_ready in OP so the word accept and the command fire are one event
   always_comb begin
      busy              = (state != ST_IDLE);
      done              = (state == ST_DONE);
      in_ready          = 1'b0;
      m_cmd_valid       = 1'b0;
      m_cmd_function_id = FN_SET_TYPE;
      m_cmd_inputs_0    = '0;
      m_cmd_inputs_1    = '0;
      m_rsp_ready       = 1'b0;
      case (state)
         ST_CFG: begin
            m_cmd_valid    = 1'b1;
            m_cmd_inputs_0 = {{(DATA_W-1){1'b0}}, signed_q};
            m_rsp_ready    = 1'b1;
         end
         ST_CFG_RSP: begin
            m_rsp_ready = 1'b1;
         end
         ST_FIRST: begin
            in_ready = 1'b1;
         end
         ST_OP: begin
            m_cmd_valid       = in_valid;
            in_ready          = m_cmd_ready;
            m_cmd_function_id = op_min_q ? FN_MIN : FN_MAX;
            m_cmd_inputs_0    = acc;
            m_cmd_inputs_1    = in_data;
            m_rsp_ready       = 1'b1;
         end
         ST_OP_RSP: begin
            m_rsp_ready = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_user_def_min_max_reduce_seq.sv
// Self-checking bench: sequencer plus a behavioural zero-wait min/max accelerator,
// expected results queued at start and compared when done pulses.
module tb_user_def_min_max_reduce_seq;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             op_min;
   logic             is_signed;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic [31:0]      result;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             m_cmd_valid;
   logic             m_cmd_ready;
   logic [9:0]       m_cmd_function_id;
   logic [31:0]      m_cmd_inputs_0;
   logic [31:0]      m_cmd_inputs_1;
   logic             m_rsp_valid;
   logic             m_rsp_ready;
   logic [31:0]      m_rsp_outputs_0;

   int n_assert = 0;
   int n_fail   = 0;

   user_def_min_max_reduce_seq #(.LEN_W(LEN_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .op_min            (op_min),
      .is_signed         (is_signed),
      .len               (len),
      .busy              (busy),
      .done              (done),
      .result            (result),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .m_cmd_valid       (m_cmd_valid),
      .m_cmd_ready       (m_cmd_ready),
      .m_cmd_function_id (m_cmd_function_id),
      .m_cmd_inputs_0    (m_cmd_inputs_0),
      .m_cmd_inputs_1    (m_cmd_inputs_1),
      .m_rsp_valid       (m_rsp_valid),
      .m_rsp_ready       (m_rsp_ready),
      .m_rsp_outputs_0   (m_rsp_outputs_0)
   );

   always #5 clk = ~clk;

   // Accelerator model: one outstanding command, response the cycle after it is accepted.
   logic        acc_pending;
   logic        acc_type_signed;
   logic [31:0] acc_rsp;
   logic        cmd_stall = 1'b0;

   assign m_cmd_ready     = m_rsp_ready && !acc_pending && !cmd_stall;
   assign m_rsp_valid     = acc_pending;
   assign m_rsp_outputs_0 = acc_rsp;

   function automatic logic [31:0] lane_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn, input logic mn);
      logic [31:0] r;
      logic [7:0]  x;
      logic [7:0]  y;
      logic        lt;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         x  = a[8*i +: 8];
         y  = b[8*i +: 8];
         lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
         r[8*i +: 8] = (mn ? lt : !lt) ? x : y;
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_pending     <= 1'b0;
         acc_type_signed <= 1'b0;
         acc_rsp         <= '0;
      end else begin
         if (acc_pending && m_rsp_ready) acc_pending <= 1'b0;
         if (m_cmd_valid && m_cmd_ready) begin
            acc_pending <= 1'b1;
            case (m_cmd_function_id)
               10'd0: begin
                  acc_type_signed <= m_cmd_inputs_0[0];
                  acc_rsp         <= '0;
               end
               10'd1:   acc_rsp <= lane_op(m_cmd_inputs_0, m_cmd_inputs_1, acc_type_signed, 1'b0);
               default: acc_rsp <= lane_op(m_cmd_inputs_0, m_cmd_inputs_1, acc_type_signed, 1'b1);
            endcase
         end
      end
   end

   // Monitors: cycle count, command log, word accepts and done pulses.
   int          cyc = 0;
   int          cmd_count = 0;
   int          cmd_valid_cycles = 0;
   int          consumed = 0;
   int          done_count = 0;
   logic [9:0]  fn_log[$];
   logic        take = 1'b0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (m_cmd_valid) cmd_valid_cycles = cmd_valid_cycles + 1;
      if (reset_n && m_cmd_valid && m_cmd_ready) begin
         cmd_count = cmd_count + 1;
         fn_log.push_back(m_cmd_function_id);
      end
      take = in_valid && in_ready;
      if (take) consumed = consumed + 1;
      if (done) done_count = done_count + 1;
   end

   // Word feeder: presents the head of word_q, with optional random valid gaps and cmd stalls.
   logic [31:0] word_q[$];
   logic [31:0] exp_q[$];
   bit          gap_en = 1'b0;

   always @(negedge clk) begin
      if (take && word_q.size() > 0) void'(word_q.pop_front());
      in_valid  = (word_q.size() > 0) && !(gap_en && $urandom_range(0, 2) == 0);
      in_data   = (word_q.size() > 0) ? word_q[0] : 32'h0;
      cmd_stall = gap_en && ($urandom_range(0, 3) == 0);
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input string tag, input bit op, input bit sgn, input int n,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3,
                                 input logic [31:0] expected, input bit stray, input bit check_lat);
      logic [31:0] words [4];
      logic [31:0] exp;
      int cb, fb, wb, db, vb, s, dc, k;
      bit busy_drop;
      words = '{w0, w1, w2, w3};
      cb = cmd_count; fb = fn_log.size(); wb = consumed; db = done_count; vb = cmd_valid_cycles;
      busy_drop = 1'b0;
      for (int i = 0; i < n; i++) word_q.push_back(words[i]);
      word_q.push_back(32'hA5A5_A5A5);
      exp_q.push_back(expected);
      @(negedge clk);
      op_min = op; is_signed = sgn; len = LEN_W'(n); start = 1'b1;
      @(posedge clk);
      #1 s = cyc;
      @(negedge clk);
      start = 1'b0;
      check_output({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      k = 0;
      while (!done && k < 400) begin
         if (!busy) busy_drop = 1'b1;
         start = stray && ($urandom_range(0, 3) == 0);
         if (start) len = LEN_W'(3);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      dc = cyc;
      check_output({tag, " done_seen"}, {31'b0, done}, 32'd1);
      exp = exp_q.pop_front();
      check_output({tag, " result"}, result, exp);
      check_output({tag, " busy_held"}, {31'b0, busy_drop}, 32'd0);
      if (check_lat)
         check_output({tag, " latency"}, dc - s, (n == 0) ? 32'd0 : 32'(2 * n + 1));
      check_output({tag, " cmd_count"}, cmd_count - cb, 32'(n));
      if (n == 0)
         check_output({tag, " no_cmd_valid"}, cmd_valid_cycles - vb, 32'd0);
      if (n > 0)
         check_output({tag, " first_fn"}, {22'b0, fn_log[fb]}, 32'd0);
      if (n > 1)
         check_output({tag, " op_fn"}, {22'b0, fn_log[fn_log.size() - 1]}, op ? 32'd2 : 32'd1);
      @(negedge clk);
      check_output({tag, " done_pulse_1cyc"}, {31'b0, done}, 32'd0);
      check_output({tag, " result_held"}, result, exp);
      repeat (3) @(negedge clk);
      check_output({tag, " words_consumed"}, consumed - wb, 32'(n));
      check_output({tag, " done_count"}, done_count - db, 32'd1);
      word_q.delete();
      @(negedge clk);
   endtask

   initial begin
      int cb, db, k;
      reset_n = 1'b0; start = 1'b0; op_min = 1'b0; is_signed = 1'b0; len = '0;
      repeat (3) @(negedge clk);
      check_output("reset busy", {31'b0, busy}, 32'd0);
      check_output("reset done", {31'b0, done}, 32'd0);
      check_output("reset result", result, 32'd0);
      check_output("reset in_ready", {31'b0, in_ready}, 32'd0);
      check_output("reset cmd_valid", {31'b0, m_cmd_valid}, 32'd0);
      check_output("reset rsp_ready", {31'b0, m_rsp_ready}, 32'd0);
      check_output("reset fn_id", {22'b0, m_cmd_function_id}, 32'd0);
      check_output("reset inputs_0", m_cmd_inputs_0, 32'd0);
      check_output("reset inputs_1", m_cmd_inputs_1, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      apply_stimulus("umax", 1'b0, 1'b0, 2, 32'h01FF7F80, 32'h02008081, 32'h0, 32'h0,
                     32'h02FF8081, 1'b0, 1'b1);
      apply_stimulus("smax", 1'b0, 1'b1, 2, 32'h01FF7F80, 32'h02008081, 32'h0, 32'h0,
                     32'h02007F81, 1'b0, 1'b1);
      apply_stimulus("smin", 1'b1, 1'b1, 2, 32'h01FF7F80, 32'h02008081, 32'h0, 32'h0,
                     32'h01FF8080, 1'b0, 1'b1);
      apply_stimulus("umin4", 1'b1, 1'b0, 4, 32'h10203040, 32'h05213F41, 32'h11061242, 32'h12223307,
                     32'h05061207, 1'b0, 1'b1);
      apply_stimulus("len0", 1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h00000000, 1'b0, 1'b1);
      apply_stimulus("len1", 1'b0, 1'b1, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                     32'hDEADBEEF, 1'b0, 1'b1);

      gap_en = 1'b1;
      apply_stimulus("gaps_umin4", 1'b1, 1'b0, 4, 32'h10203040, 32'h05213F41, 32'h11061242, 32'h12223307,
                     32'h05061207, 1'b1, 1'b0);
      gap_en = 1'b0;
      repeat (2) @(negedge clk);

      // Abort a len=4 run while its first fold command is outstanding.
      cb = cmd_count;
      for (int i = 0; i < 4; i++) word_q.push_back(32'h11111111 * (i + 1));
      exp_q.push_back(32'h44444444);
      @(negedge clk);
      op_min = 1'b0; is_signed = 1'b0; len = LEN_W'(4); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while ((cmd_count - cb) < 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_output("abort reached op_rsp", {31'b0, m_rsp_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_output("abort busy", {31'b0, busy}, 32'd0);
      check_output("abort done", {31'b0, done}, 32'd0);
      check_output("abort result", result, 32'd0);
      check_output("abort in_ready", {31'b0, in_ready}, 32'd0);
      check_output("abort cmd_valid", {31'b0, m_cmd_valid}, 32'd0);
      check_output("abort rsp_ready", {31'b0, m_rsp_ready}, 32'd0);
      check_output("abort fn_id", {22'b0, m_cmd_function_id}, 32'd0);
      check_output("abort inputs_0", m_cmd_inputs_0, 32'd0);
      check_output("abort inputs_1", m_cmd_inputs_1, 32'd0);
      void'(exp_q.pop_front());
      word_q.delete();
      db = done_count;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check_output("abort no_done_leak", done_count - db, 32'd0);

      apply_stimulus("after_abort", 1'b0, 1'b0, 2, 32'h01FF7F80, 32'h02008081, 32'h0, 32'h0,
                     32'h02FF8081, 1'b0, 1'b1);

      check_output("scoreboard empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
